instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage fed by the 8-bit program counter; the PC increments once per clock, and this stage turns each PC value into an instruction for decode. It reads a 256-word synchronous instruction memory, registers the read, and queues the fetched instruction with its PC in a 4-entry FIFO. Decode pulls entries with a valid/ready handshake, so it can stall while the PC keeps counting. A flush input discards everything in flight on a branch or restart, and a sticky flag reports any fetched word lost to a full queue.

## Interface
- DATA_W, 16, instruction width in bits
- QDEPTH, 4, queue entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- pc  in  8  fetch address from program counter
- fetch_en  in  1  fetch mem[pc] this cycle
- imem_we  in  1  program-load write strobe
- imem_waddr  in  8  program-load address
- imem_wdata  in  DATA_W  program-load data
- flush  in  1  discard in-flight read and all queued entries
- id_ready  in  1  decode accepts head entry this cycle
- instr  out  DATA_W  head instruction; 0 when instr_valid low
- instr_pc  out  8  PC of head instruction; 0 when instr_valid low
- instr_valid  out  1  queue non-empty
- q_count  out  clog2(QDEPTH)+1  entries held, 0..QDEPTH
- overflow  out  1  sticky: a fetched word was dropped

## Operation
- Memory: 256 × DATA_W. Write occurs at the edge when imem_we=1. A read of the same address at the same edge returns the old data. Contents are not cleared by rst.
- Stage F1 registers: rd_valid, rd_data, rd_pc. At each edge:
  - rd_valid ← fetch_en & ~flush
  - rd_data ← mem[pc]
  - rd_pc ← pc
- Queue push: at the edge when rd_valid=1 and flush=0, the pair {rd_data, rd_pc} is written at the tail.
- Queue pop: at the edge when instr_valid=1, id_ready=1 and flush=0, the head advances.
- Full queue with push requested:
  - With a pop at the same edge, push and pop both occur and q_count is unchanged.
  - Without a pop, the push is dropped, the queue is unchanged and overflow←1.
- Empty queue with push and pop at the same edge: the pop is ignored (instr_valid=0), the push occurs, and q_count becomes 1.
- Flush: at the edge, head and tail pointers reset, q_count←0, rd_valid←0 and overflow←0. Flush takes priority over push, pop and fetch_en at that edge. Memory writes are unaffected.
- Pointers are clog2(QDEPTH) bits and wrap modulo QDEPTH. q_count is tracked separately to distinguish full from empty.
- id_ready while empty has no effect.
- instr, instr_pc and instr_valid are decoded combinationally from the queue head and q_count. instr and instr_pc are forced to 0 when empty.

## Timing
- Reset (async, any time):
  - rd_valid=0, pointers=0, q_count=0, overflow=0
  - Outputs instr=0, instr_pc=0, instr_valid=0 immediately on assertion, with no clock needed.
  - The first fetch can be sampled at the first rising edge after rst deasserts.
- Latency: pc sampled at edge N → entry in queue after edge N+1 → instr_valid high during cycle N+1. Two edges, empty queue, no flush.
- Throughput: one fetch per cycle sustained while id_ready=1 every cycle. The queue then holds ≤1 entry.
- Stall: with id_ready=0 and fetch_en=1 every cycle, the queue fills in QDEPTH cycles. Every later fetch sets overflow.
- Flush at edge N: instr_valid=0 during cycle N+1. A fetch sampled at edge N is also discarded. A fetch sampled at edge N+1 becomes valid after edge N+2.
- Reset asserted mid-operation discards in-flight and queued data exactly as flush does, and additionally clears overflow asynchronously.

## Test plan
- Load: write mem[k]=16'hA000+k for k=0..7, then fetch with pc=0..7 and id_ready=1 every cycle. Required: instr=A000..A007 and instr_pc=0..7 on consecutive cycles, first valid 2 edges after pc=0 is sampled, q_count ≤1.
- Stall/fill: id_ready=0, fetch pc=0..5. Required: q_count reaches 4 holding pc 0..3. Fetches at pc 4 and 5 are dropped, overflow=1. Then id_ready=1 drains A000..A003 in order and overflow stays 1.
- Full with simultaneous push/pop: q_count=4, id_ready=1 for one cycle while the fetch at pc=4 arrives. Required: q_count stays 4, the head advances to pc 1, the tail is pc 4, overflow=0.
- Flush: 3 entries queued plus one in F1, flush=1 with fetch_en=1. Required: instr_valid=0 and q_count=0 next cycle, overflow cleared. The fetch at pc=9 sampled on the following edge appears alone with instr_pc=9.
- Read-during-write: mem[3]=1111, then at the same edge imem_we writes mem[3]=2222 and fetch pc=3. Required: the fetched instr is 1111. A refetch of pc=3 returns 2222.
- Async reset mid-stream: assert rst between edges with 2 entries queued. Required: instr_valid, q_count, instr and instr_pc go to 0 immediately. After release, mem contents are still intact.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program-counter/program-load inputs, flush, and the
// decode-facing valid/ready queue head plus status.
interface instruction_fetch_if #(
    parameter int DATA_W = 16,
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [7:0]        pc;
    logic              fetch_en;
    logic              imem_we;
    logic [7:0]        imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              flush;
    logic              id_ready;
    logic [DATA_W-1:0] instr;
    logic [7:0]        instr_pc;
    logic              instr_valid;
    logic [CW-1:0]     q_count;
    logic              overflow;

    modport master (
        output pc, fetch_en, imem_we, imem_waddr, imem_wdata, flush, id_ready,
        input  instr, instr_pc, instr_valid, q_count, overflow
    );

    modport slave (
        input  pc, fetch_en, imem_we, imem_waddr, imem_wdata, flush, id_ready,
        output instr, instr_pc, instr_valid, q_count, overflow
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: synchronous 256-word imem, one registered read stage,
// and a small FIFO of {instr, pc} pairs drained by decode.
module instruction_fetch #(
    parameter int DATA_W = 16,
    parameter int QDEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.slave  bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] rd_data_q;
    logic [7:0]        rd_pc_q;
    logic              rd_valid_q, rd_valid_d;

    logic [DATA_W-1:0] qdata_q [QDEPTH];
    logic [7:0]        qpc_q   [QDEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;

    logic push_req, pop, full, push, drop;

    // Memory and read data carry no reset so the array maps onto block RAM;
    // the registered read sees pre-write contents on a same-address write.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_waddr] <= bus.imem_wdata;
        end
        rd_data_q <= mem[bus.pc];
        rd_pc_q   <= bus.pc;
    end

    assign full     = (count_q == CW'(QDEPTH));
    assign push_req = rd_valid_q & ~bus.flush;
    assign pop      = (count_q != '0) & bus.id_ready & ~bus.flush;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        rd_valid_d = bus.fetch_en & ~bus.flush;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            head_d     = pop  ? head_q + PW'(1) : head_q;
            tail_d     = push ? tail_q + PW'(1) : tail_q;
            count_d    = count_q + CW'(push) - CW'(pop);
            overflow_d = overflow_q | drop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_q == PW'(gi))) begin
                    qdata_q[gi] <= rd_data_q;
                    qpc_q[gi]   <= rd_pc_q;
                end
            end
        end
    endgenerate

    // Entry storage is never cleared, so the head is masked while empty.
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = bus.instr_valid ? qdata_q[head_q] : '0;
    assign bus.instr_pc    = bus.instr_valid ? qpc_q[head_q]   : '0;
    assign bus.q_count     = count_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a queue-based reference model.
module tb_instruction_fetch;
    localparam int DATA_W = 16;
    localparam int QDEPTH = 4;

    logic clk;
    logic rst;

    instruction_fetch_if #(.DATA_W(DATA_W), .QDEPTH(QDEPTH)) bus ();

    instruction_fetch #(.DATA_W(DATA_W), .QDEPTH(QDEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [7:0]        pc;
    } ent_t;

    logic [DATA_W-1:0] m_mem [256];
    ent_t              m_q [$];
    bit                m_rdv;
    logic [DATA_W-1:0] m_rdd;
    logic [7:0]        m_rdpc;
    bit                m_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ovf = 0;
        m_rdv = 0;
    endtask

    // Reference behaviour at one rising edge, from the inputs held across it.
    task automatic model_edge();
        ent_t e;
        bit push_req, pop, full;
        push_req = m_rdv && !bus.flush;
        pop      = (m_q.size() != 0) && bus.id_ready && !bus.flush;
        full     = (m_q.size() == QDEPTH);
        e.d  = m_rdd;
        e.pc = m_rdpc;
        if (rst || bus.flush) begin
            model_clear();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push_req) begin
                if (!full || pop) m_q.push_back(e);
                else m_ovf = 1;
            end
            m_rdv = bus.fetch_en;
        end
        m_rdd  = m_mem[bus.pc];
        m_rdpc = bus.pc;
        if (bus.imem_we) m_mem[bus.imem_waddr] = bus.imem_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [DATA_W-1:0] d);
        bus.imem_we    = 1;
        bus.imem_waddr = a;
        bus.imem_wdata = d;
        tick();
        bus.imem_we = 0;
    endtask

    task automatic do_flush();
        bus.flush = 1;
        tick();
        bus.flush = 0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic              ev;
            logic [DATA_W-1:0] ei;
            logic [7:0]        ep;
            ev = (m_q.size() != 0);
            ei = ev ? m_q[0].d  : '0;
            ep = ev ? m_q[0].pc : '0;
            chk("cyc_valid", 32'(bus.instr_valid), 32'(ev));
            chk("cyc_instr", 32'(bus.instr), 32'(ei));
            chk("cyc_pc", 32'(bus.instr_pc), 32'(ep));
            chk("cyc_count", 32'(bus.q_count), 32'(m_q.size()));
            chk("cyc_ovf", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    initial begin
        rst = 1;
        bus.pc = 0; bus.fetch_en = 0; bus.imem_we = 0; bus.imem_waddr = 0;
        bus.imem_wdata = 0; bus.flush = 0; bus.id_ready = 0;
        model_clear();
        tick();
        cmp_en = 1;
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_count", 32'(bus.q_count), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        rst = 0;
        tick();

        for (int a = 0; a < 256; a++) wr(8'(a), DATA_W'($urandom));

        // Load and stream at full rate
        for (int k = 0; k < 8; k++) wr(8'(k), 16'hA000 + 16'(k));
        bus.id_ready = 1;
        for (int k = 0; k < 10; k++) begin
            bus.pc = 8'(k);
            bus.fetch_en = (k < 8);
            tick();
            if (k == 0) chk("lat_first_invalid", 32'(bus.instr_valid), 32'd0);
            if (k >= 1 && k <= 8) begin
                chk("stream_instr", 32'(bus.instr), 32'(16'hA000 + 16'(k - 1)));
                chk("stream_pc", 32'(bus.instr_pc), 32'(k - 1));
            end
            chk("stream_q_le1", 32'(bus.q_count <= 1), 32'd1);
        end

        // Stall until full, then two dropped fetches
        bus.id_ready = 0;
        for (int k = 0; k < 6; k++) begin
            bus.pc = 8'(k);
            bus.fetch_en = 1;
            tick();
        end
        bus.fetch_en = 0;
        tick();
        chk("fill_count", 32'(bus.q_count), 32'd4);
        chk("fill_head", 32'(bus.instr_pc), 32'd0);
        chk("fill_ovf", 32'(bus.overflow), 32'd1);
        bus.id_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_instr", 32'(bus.instr), 32'(16'hA000 + 16'(k)));
            tick();
        end
        bus.id_ready = 0;
        chk("drain_empty", 32'(bus.q_count), 32'd0);
        chk("drain_ovf_sticky", 32'(bus.overflow), 32'd1);

        // Flush with three queued and one in the read stage
        for (int k = 5; k < 9; k++) begin
            bus.pc = 8'(k);
            bus.fetch_en = 1;
            tick();
        end
        chk("preflush_count", 32'(bus.q_count), 32'd3);
        bus.pc = 8'd20;
        bus.flush = 1;
        tick();
        bus.flush = 0;
        chk("flush_valid", 32'(bus.instr_valid), 32'd0);
        chk("flush_count", 32'(bus.q_count), 32'd0);
        chk("flush_ovf", 32'(bus.overflow), 32'd0);
        bus.pc = 8'd9;
        tick();
        bus.fetch_en = 0;
        chk("postflush_gap", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("postflush_pc", 32'(bus.instr_pc), 32'd9);
        chk("postflush_count", 32'(bus.q_count), 32'd1);

        // Full queue with simultaneous push and pop
        do_flush();
        for (int k = 0; k < 5; k++) begin
            bus.pc = 8'(k);
            bus.fetch_en = 1;
            tick();
        end
        bus.fetch_en = 0;
        bus.id_ready = 1;
        tick();
        bus.id_ready = 0;
        chk("pp_count", 32'(bus.q_count), 32'd4);
        chk("pp_head", 32'(bus.instr_pc), 32'd1);
        chk("pp_ovf", 32'(bus.overflow), 32'd0);
        bus.id_ready = 1;
        for (int k = 1; k < 5; k++) begin
            chk("pp_order", 32'(bus.instr_pc), 32'(k));
            tick();
        end
        bus.id_ready = 0;

        // Read during write at the same address
        do_flush();
        wr(8'd3, 16'h1111);
        bus.pc = 8'd3;
        bus.fetch_en = 1;
        wr(8'd3, 16'h2222);
        tick();
        bus.fetch_en = 0;
        tick();
        chk("rdw_old", 32'(bus.instr), 32'h1111);
        bus.id_ready = 1;
        tick();
        bus.id_ready = 0;
        chk("rdw_new", 32'(bus.instr), 32'h2222);

        // Asynchronous reset with two entries queued
        do_flush();
        for (int k = 0; k < 2; k++) begin
            bus.pc = 8'(k);
            bus.fetch_en = 1;
            tick();
        end
        bus.fetch_en = 0;
        tick();
        chk("prerst_count", 32'(bus.q_count), 32'd2);
        #1;
        rst = 1;
        model_clear();
        #1;
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_count", 32'(bus.q_count), 32'd0);
        chk("arst_instr", 32'(bus.instr), 32'd0);
        chk("arst_pc", 32'(bus.instr_pc), 32'd0);
        tick();
        tick();
        rst = 0;
        tick();
        bus.fetch_en = 1;
        bus.pc = 8'd0;
        tick();
        bus.pc = 8'd3;
        tick();
        bus.fetch_en = 0;
        tick();
        chk("mem_kept0", 32'(bus.instr), 32'hA000);
        bus.id_ready = 1;
        tick();
        chk("mem_kept3", 32'(bus.instr), 32'h2222);

        // Randomized traffic with alternating stall-heavy and drain-heavy phases
        for (int i = 0; i < 3000; i++) begin
            bus.fetch_en   = ($urandom_range(0, 9) < 8);
            bus.id_ready   = ((i / 128) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                                  : ($urandom_range(0, 3) != 0);
            bus.flush      = ($urandom_range(0, 39) == 0);
            bus.imem_we    = ($urandom_range(0, 7) == 0);
            bus.imem_waddr = 8'($urandom);
            bus.imem_wdata = DATA_W'($urandom);
            bus.pc         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : bus.pc + 8'd1;
            tick();
        end
        bus.fetch_en = 0;
        bus.flush = 0;
        bus.imem_we = 0;
        tick();
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
